// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Purpose  : Instruction prefetch unit. Fetches aligned 64-bit doublewords,
//            splits them into 32-bit instructions and holds them in a
//            circular queue for the decoder. Handles redirects and keeps at
//            most one memory request outstanding.
// Options  : IFU_RSP_BYPASS_EN - when defined, a response that arrives while
//            the queue is empty is forwarded straight to inst/inst_pc in the
//            same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    // Fetch address is always word aligned, so only bits [63:2] are kept.
    logic [63:2]        r_fetch_pc;

    logic [31:0]        r_q_inst [DEPTH];
    logic [63:0]        r_q_pc   [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [c_CNT_W-1:0] w_free;
    logic               w_rsp_accept;
    logic               w_two_words;
    logic [31:0]        w_word0;
    logic [63:0]        w_pc0;
    logic [31:0]        w_word1;
    logic [63:0]        w_pc1;
    logic               w_bypass;
    logic               w_bypass_taken;
    logic [1:0]         w_push_n;
    logic [31:0]        w_push_inst0;
    logic [63:0]        w_push_pc0;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_tail1;
    logic               w_unused;

    // Low address bits of a redirect target are architecturally ignored.
    assign w_unused = ^redirect_pc[1:0];

    assign mem_req_addr = {r_fetch_pc[63:3], 3'b000};
    assign w_free       = c_CNT_W'(DEPTH) - r_count;

    // A response is only consumed in WAIT and only if no redirect kills it.
    assign w_rsp_accept = (r_state == c_ST_WAIT) && mem_rsp_valid && !redirect_valid;
    assign w_two_words  = !r_fetch_pc[2];
    assign w_word0      = r_fetch_pc[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
    assign w_pc0        = {r_fetch_pc, 2'b00};
    assign w_word1      = mem_rsp_data[63:32];
    assign w_pc1        = w_pc0 + 64'd4;
    assign w_tail1      = r_tail + c_PTR_W'(1);

`ifdef IFU_RSP_BYPASS_EN
    assign w_bypass       = w_rsp_accept && (r_count == '0) && !rst;
    assign w_bypass_taken = w_bypass && inst_ready;
`else
    assign w_bypass       = 1'b0;
    assign w_bypass_taken = 1'b0;
`endif

    // Select what gets written into the queue; a consumed bypass word skips a slot.
    always_comb begin
        w_push_n     = 2'd0;
        w_push_inst0 = w_word0;
        w_push_pc0   = w_pc0;
        if (w_rsp_accept) begin
            if (w_bypass_taken) begin
                w_push_n     = w_two_words ? 2'd1 : 2'd0;
                w_push_inst0 = w_word1;
                w_push_pc0   = w_pc1;
            end else begin
                w_push_n     = w_two_words ? 2'd2 : 2'd1;
            end
        end
    end

    assign w_pop = (r_count != '0) && inst_ready;

    // State register; a reset with a request in flight must still swallow its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ((r_state == c_ST_IDLE) || mem_rsp_valid) ? c_ST_IDLE : c_ST_DROP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the request/response handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!redirect_valid && mem_req_valid && mem_req_ready) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (mem_rsp_valid) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (redirect_valid) begin
                    w_state_nxt = c_ST_DROP;
                end
            end
            c_ST_DROP: begin
                // A response arriving together with another redirect is still the stale one.
                if (mem_rsp_valid) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs: request qualification and queue head (or bypassed response).
    always_comb begin
        mem_req_valid = 1'b0;
        inst_valid    = 1'b0;
        inst          = r_q_inst[r_head];
        inst_pc       = r_q_pc[r_head];
        if (!rst) begin
            mem_req_valid = (r_state == c_ST_IDLE) && (w_free >= c_CNT_W'(2)) && !redirect_valid;
            inst_valid    = (r_count != '0) || w_bypass;
            if (w_bypass) begin
                inst    = w_word0;
                inst_pc = w_pc0;
            end
        end
    end

    // Fetch address: reset, redirect, or advance past the words just consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC[63:2];
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc[63:2];
        end else if (w_rsp_accept) begin
            r_fetch_pc <= r_fetch_pc + (w_two_words ? 62'd2 : 62'd1);
        end
    end

    // Circular instruction queue; redirect flushes it and discards same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_inst[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_n != 2'd0) begin
                r_q_inst[r_tail] <= w_push_inst0;
                r_q_pc[r_tail]   <= w_push_pc0;
            end
            if (w_push_n == 2'd2) begin
                r_q_inst[w_tail1] <= w_word1;
                r_q_pc[w_tail1]   <= w_pc1;
            end
            r_tail <= r_tail + c_PTR_W'(w_push_n);
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push_n) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire
